// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial sequence detector.
// Holds the FSM state encoding, config reset defaults and history sizing.
package seq_detect_pkg;

  localparam int HIST_W = 8;
  localparam int HCNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [HIST_W-1:0] CFG_PATTERN_RST = 8'h0B;
  localparam logic [2:0]        CFG_LEN_RST     = 3'd3;
  localparam logic              CFG_OVERLAP_RST = 1'b0;
  localparam logic [7:0]        CFG_TARGET_RST  = 8'd0;

  // Mask selecting the low L = len+1 bits of the history.
  function automatic logic [HIST_W-1:0] len_mask(input logic [2:0] len);
    return 8'hFF >> (3'd7 - len);
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/seq_detect_ctrl_if.sv
// Bus bundle for seq_detect_ctrl: config, run control, serial input and status.
// Serial input: a bit transfers on a rising clk edge where in_valid && in_ready.
interface seq_detect_ctrl_if;
  import seq_detect_pkg::*;

  logic              cfg_we;
  logic [HIST_W-1:0] cfg_pattern;
  logic [2:0]        cfg_len;
  logic              cfg_overlap;
  logic [7:0]        cfg_target;
  logic              start;
  logic              abort;
  logic              in_valid;
  logic              in_bit;
  logic              in_ready;
  logic              match;
  logic [7:0]        match_cnt;
  logic              busy;
  logic              done;
  state_t            state;

  modport master (
    output cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    output start, abort, in_valid, in_bit,
    input  in_ready, match, match_cnt, busy, done, state
  );

  modport slave (
    input  cfg_we, cfg_pattern, cfg_len, cfg_overlap, cfg_target,
    input  start, abort, in_valid, in_bit,
    output in_ready, match, match_cnt, busy, done, state
  );

endinterface

// File: rtl/seq_shift_match.sv
// Bit history shift register, saturating history counter and masked pattern
// comparator. o_match_hit is combinational for the bit being accepted now.
module seq_shift_match
  import seq_detect_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic              i_bit,
  input  logic [HIST_W-1:0] i_pattern,
  input  logic [2:0]        i_len,
  input  logic              i_overlap,
  output logic              o_match_hit
);

  logic [HIST_W-1:0] r_shift;
  logic [HCNT_W-1:0] r_hist;

  logic [HIST_W-1:0] w_shift_next;
  logic [HIST_W-1:0] w_mask;
  logic [HCNT_W-1:0] w_hist_next;
  logic [HCNT_W-1:0] w_len_full;

  assign w_shift_next = {r_shift[HIST_W-2:0], i_bit};
  assign w_hist_next  = (r_hist == HCNT_W'(HIST_W)) ? r_hist : r_hist + 1'b1;
  assign w_len_full   = {1'b0, i_len} + 1'b1;
  assign w_mask       = len_mask(i_len);

  assign o_match_hit = i_accept
                    && (w_hist_next >= w_len_full)
                    && ((w_shift_next & w_mask) == (i_pattern & w_mask));

  // Non-overlap mode forgets the history after a hit so the next match
  // needs L fresh bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_hist  <= '0;
    end else if (i_clear) begin
      r_shift <= '0;
      r_hist  <= '0;
    end else if (i_accept) begin
      r_shift <= w_shift_next;
      r_hist  <= (o_match_hit && !i_overlap) ? '0 : w_hist_next;
    end
  end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Serial sequence detector controller: run FSM, config registers, match counter
// and registered match pulse around the seq_shift_match datapath.
module seq_detect_ctrl
  import seq_detect_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  seq_detect_ctrl_if.slave bus
);

  state_t            r_state;
  logic [HIST_W-1:0] r_pattern;
  logic [2:0]        r_len;
  logic              r_overlap;
  logic [7:0]        r_target;
  logic              r_match;
  logic [7:0]        r_match_cnt;
  logic              r_in_ready;
  logic              r_busy;
  logic              r_done;

  logic       w_accept;
  logic       w_hit;
  logic       w_start_run;
  logic [7:0] w_cnt_next;
  logic       w_terminal;

  assign w_accept    = bus.in_valid && r_in_ready;
  assign w_start_run = (r_state != ST_RUN) && bus.start && !bus.abort;
  assign w_cnt_next  = sat_inc8(r_match_cnt);
  assign w_terminal  = (r_target != 8'd0) && (w_cnt_next == r_target);

  seq_shift_match u_shift_match (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_start_run),
    .i_accept    (w_accept),
    .i_bit       (bus.in_bit),
    .i_pattern   (r_pattern),
    .i_len       (r_len),
    .i_overlap   (r_overlap),
    .o_match_hit (w_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pattern   <= CFG_PATTERN_RST;
      r_len       <= CFG_LEN_RST;
      r_overlap   <= CFG_OVERLAP_RST;
      r_target    <= CFG_TARGET_RST;
      r_match     <= 1'b0;
      r_match_cnt <= 8'd0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_match <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          // Config loads on the same edge as a start, so the new run sees it.
          if (bus.cfg_we) begin
            r_pattern <= bus.cfg_pattern;
            r_len     <= bus.cfg_len;
            r_overlap <= bus.cfg_overlap;
            r_target  <= bus.cfg_target;
          end
          if (bus.abort) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
          end else if (bus.start) begin
            r_state     <= ST_RUN;
            r_match_cnt <= 8'd0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
          end
        end
        ST_RUN: begin
          if (bus.abort) begin
            r_state    <= ST_IDLE;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
          end else if (w_hit) begin
            r_match     <= 1'b1;
            r_match_cnt <= w_cnt_next;
            if (w_terminal) begin
              r_state    <= ST_DONE;
              r_in_ready <= 1'b0;
              r_busy     <= 1'b0;
              r_done     <= 1'b1;
            end
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_in_ready <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.match     = r_match;
  assign bus.match_cnt = r_match_cnt;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.state     = r_state;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: inputs change on the falling edge,
// outputs are sampled on the falling edge after the capturing rising edge.
module tb_seq_detect_ctrl;
  import seq_detect_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  seq_detect_ctrl_if bus();

  seq_detect_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- driver tasks (called at a falling edge) ----------------
  task automatic idle_inputs();
    bus.cfg_we      = 1'b0;
    bus.cfg_pattern = 8'h00;
    bus.cfg_len     = 3'd0;
    bus.cfg_overlap = 1'b0;
    bus.cfg_target  = 8'd0;
    bus.start       = 1'b0;
    bus.abort       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_bit      = 1'b0;
  endtask

  task automatic do_cfg(input logic [7:0] pat, input logic [2:0] len,
                        input logic ov, input logic [7:0] tgt);
    bus.cfg_we      = 1'b1;
    bus.cfg_pattern = pat;
    bus.cfg_len     = len;
    bus.cfg_overlap = ov;
    bus.cfg_target  = tgt;
    @(negedge clk);
    bus.cfg_we      = 1'b0;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
  endtask

  // Sends n bits MSB-first on consecutive cycles; hits[i] = match seen after bit i.
  task automatic send_bits(input logic [31:0] bits, input int n, output logic [31:0] hits);
    hits = '0;
    for (int i = 0; i < n; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = bits[n-1-i];
      @(negedge clk);
      if (bus.match === 1'b1) hits[i] = 1'b1;
    end
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", bus.state, ST_IDLE); end
    n_checks++; if (bus.match !== 1'b0) begin n_fail++; $display("FAIL reset_match: got %b want 0", bus.match); end
    n_checks++; if (bus.match_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", bus.match_cnt); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", bus.done); end
  endtask

  task automatic test_basic();
    logic [31:0] hits;
    do_start();
    n_checks++; if (bus.state !== ST_RUN) begin n_fail++; $display("FAIL basic_state_run: got %0d want %0d", bus.state, ST_RUN); end
    n_checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_ready_busy: got %b%b want 11", bus.in_ready, bus.busy); end
    send_bits(32'b1011, 4, hits);
    n_checks++; if (hits !== 32'h8) begin n_fail++; $display("FAIL basic_hits: got %0h want 8", hits); end
    n_checks++; if (bus.match_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", bus.match_cnt); end
    @(negedge clk);
    n_checks++; if (bus.match !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b want 0", bus.match); end
  endtask

  task automatic test_overlap();
    logic [31:0] hits;
    do_abort();
    n_checks++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL ovl_abort_idle: got %0d want %0d", bus.state, ST_IDLE); end
    do_cfg(8'h0B, 3'd3, 1'b0, 8'd0);
    do_start();
    send_bits(32'b1011011, 7, hits);
    n_checks++; if (hits !== 32'h08) begin n_fail++; $display("FAIL nonovl_hits: got %0h want 08", hits); end
    n_checks++; if (bus.match_cnt !== 8'd1) begin n_fail++; $display("FAIL nonovl_cnt: got %0d want 1", bus.match_cnt); end
    do_abort();
    do_cfg(8'h0B, 3'd3, 1'b1, 8'd0);
    do_start();
    send_bits(32'b1011011, 7, hits);
    n_checks++; if (hits !== 32'h48) begin n_fail++; $display("FAIL ovl_hits: got %0h want 48", hits); end
    n_checks++; if (bus.match_cnt !== 8'd2) begin n_fail++; $display("FAIL ovl_cnt: got %0d want 2", bus.match_cnt); end
  endtask

  task automatic test_target();
    logic [31:0] hits;
    do_abort();
    do_cfg(8'h01, 3'd0, 1'b0, 8'd2);
    do_start();
    send_bits(32'b11111, 5, hits);
    n_checks++; if (hits !== 32'h3) begin n_fail++; $display("FAIL tgt_hits: got %0h want 3", hits); end
    n_checks++; if (bus.done !== 1'b1) begin n_fail++; $display("FAIL tgt_done: got %b want 1", bus.done); end
    n_checks++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL tgt_in_ready: got %b want 0", bus.in_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL tgt_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.match_cnt !== 8'd2) begin n_fail++; $display("FAIL tgt_cnt: got %0d want 2", bus.match_cnt); end
    n_checks++; if (bus.state !== ST_DONE) begin n_fail++; $display("FAIL tgt_state: got %0d want %0d", bus.state, ST_DONE); end
  endtask

  task automatic test_abort_start();
    logic [31:0] hits;
    // From DONE: reconfigure and restart.
    do_cfg(8'h0B, 3'd3, 1'b0, 8'd0);
    do_start();
    send_bits(32'b1011, 4, hits);
    n_checks++; if (hits !== 32'h8) begin n_fail++; $display("FAIL as_run_hits: got %0h want 8", hits); end
    bus.abort = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.start = 1'b0;
    n_checks++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL as_state: got %0d want %0d", bus.state, ST_IDLE); end
    n_checks++; if (bus.match_cnt !== 8'd1) begin n_fail++; $display("FAIL as_cnt_held: got %0d want 1", bus.match_cnt); end
    n_checks++; if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL as_busy_ready: got %b%b want 00", bus.busy, bus.in_ready); end
    do_start();
    n_checks++; if (bus.match_cnt !== 8'd0) begin n_fail++; $display("FAIL as_cnt_clear: got %0d want 0", bus.match_cnt); end
    do_cfg(8'h01, 3'd0, 1'b0, 8'd1);
    send_bits(32'b1011, 4, hits);
    n_checks++; if (hits !== 32'h8) begin n_fail++; $display("FAIL cfg_in_run_hits: got %0h want 8", hits); end
    n_checks++; if (bus.match_cnt !== 8'd1) begin n_fail++; $display("FAIL cfg_in_run_cnt: got %0d want 1", bus.match_cnt); end
    n_checks++; if (bus.state !== ST_RUN) begin n_fail++; $display("FAIL cfg_in_run_state: got %0d want %0d", bus.state, ST_RUN); end
  endtask

  task automatic test_saturate();
    int nm;
    nm = 0;
    do_abort();
    do_cfg(8'h01, 3'd0, 1'b0, 8'd0);
    do_start();
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'b1;
      bus.in_bit   = 1'b1;
      @(negedge clk);
      if (bus.match === 1'b1) nm++;
    end
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    n_checks++; if (nm !== 300) begin n_fail++; $display("FAIL sat_pulses: got %0d want 300", nm); end
    n_checks++; if (bus.match_cnt !== 8'd255) begin n_fail++; $display("FAIL sat_cnt: got %0d want 255", bus.match_cnt); end
    n_checks++; if (bus.state !== ST_RUN || bus.busy !== 1'b1) begin n_fail++; $display("FAIL sat_state: got %0d/%b want %0d/1", bus.state, bus.busy, ST_RUN); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] hits;
    do_abort();
    do_cfg(8'h0B, 3'd3, 1'b1, 8'd0);
    do_start();
    send_bits(32'b101, 3, hits);
    n_checks++; if (hits !== 32'h0) begin n_fail++; $display("FAIL rm_partial_hits: got %0h want 0", hits); end
    bus.in_valid = 1'b1;
    bus.in_bit   = 1'b1;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.state !== ST_IDLE) begin n_fail++; $display("FAIL rm_state: got %0d want %0d", bus.state, ST_IDLE); end
    n_checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_fail++; $display("FAIL rm_flags: got %b%b%b want 000", bus.in_ready, bus.busy, bus.done); end
    n_checks++; if (bus.match_cnt !== 8'd0) begin n_fail++; $display("FAIL rm_cnt: got %0d want 0", bus.match_cnt); end
    @(posedge clk); #1;
    n_checks++; if (bus.match !== 1'b0) begin n_fail++; $display("FAIL rm_no_match: got %b want 0", bus.match); end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_bit   = 1'b0;
    do_start();
    // Overlap should be back at its default (off): only one hit in 1011011.
    send_bits(32'b1011011, 7, hits);
    n_checks++; if (hits !== 32'h08) begin n_fail++; $display("FAIL rm_restart_hits: got %0h want 08", hits); end
    n_checks++; if (bus.match_cnt !== 8'd1) begin n_fail++; $display("FAIL rm_restart_cnt: got %0d want 1", bus.match_cnt); end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overlap();
    test_target();
    test_abort_start();
    test_saturate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 cfg_we  input  1  config write strobe; accepted only in IDLE or DONE.
REQ-004 cfg_pattern  input  8  pattern; bit (L-1) is the oldest bit, bit 0 the newest.
REQ-005 cfg_len  input  3  pattern length minus one; L = cfg_len+1 (1..8).
REQ-006 cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
REQ-007 cfg_target  input  8  match count that ends a run; 0 = unlimited.
REQ-008 start  input  1  one-cycle pulse; begins a run from IDLE or DONE.
REQ-009 abort  input  1  one-cycle pulse; ends a run and returns to IDLE.
REQ-010 in_valid  input  1  serial bit valid.
REQ-011 in_bit  input  1  serial data bit.
REQ-012 in_ready  output  1  bit acceptance; high only in RUN.
REQ-013 match  output  1  registered one-cycle pulse per detected pattern.
REQ-014 match_cnt  output  8  matches in the current or last run.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  high in DONE.

Function
REQ-017 FSM states: IDLE, RUN, DONE.
REQ-018 IDLE -> RUN on start; DONE -> RUN on start; RUN -> IDLE on abort; DONE -> IDLE on abort; RUN -> DONE when match_cnt_next == cfg_target_reg and cfg_target_reg != 0.
REQ-019 abort shall take priority over start in the same cycle, and over a same-cycle terminal match.
REQ-020 Entering RUN shall clear match_cnt, the history shift register and the history count.
REQ-021 A bit shall be accepted when in_valid && in_ready; there is no other acceptance path.
REQ-022 On acceptance: shift_next = {shift[6:0], in_bit}; hist_next = min(hist+1, 8).
REQ-023 Match condition: hist_next >= L and shift_next[L-1:0] == pattern_reg[L-1:0].
REQ-024 match shall assert in the cycle after the completing bit is accepted (latency 1) and shall be high for exactly one cycle.
REQ-025 After a match, overlap mode keeps the history; non-overlap mode clears hist to 0, so the next match needs L fresh bits.
REQ-026 match_cnt shall increment by one per match and saturate at 255.
REQ-027 The terminal match shall still pulse match and count; in_ready shall drop in the following cycle, and no further bit is accepted.
REQ-028 cfg_we in RUN shall be ignored. cfg_we in IDLE or DONE shall load all four config registers on the same edge.
REQ-029 cfg_we together with start shall load the config first, and the run shall use the new config.
REQ-030 match_cnt and done shall hold their values in DONE and after abort until the next start.

Reset
REQ-031 On rst, outputs shall be: state IDLE, match 0, match_cnt 0, in_ready 0, busy 0, done 0.
REQ-032 On rst, internal registers shall be: shift 0, hist 0.
REQ-033 On rst, config registers shall be: pattern 8'h0B, len 3 (L=4, pattern 1011), overlap 0, target 0.
REQ-034 rst asserted mid-run shall abandon the run immediately, with no match pulse.

Structure
REQ-035 Shared package seq_detect_pkg shall hold: the state enum, the config reset defaults, and the history width constant 8.
REQ-036 One sub-module, seq_shift_match, shall hold the shift register, the history counter and the masked comparator. It shall produce a combinational match_hit. The parent shall own the FSM, the counter and the registered match.

Verification
REQ-037 Reset defaults, start, bits 1,0,1,1 on consecutive cycles -> match high one cycle after the 4th bit, match_cnt=1.
REQ-038 Default pattern, non-overlap, stream 1011011 -> one match. Same stream with overlap=1 -> two matches (after bits 4 and 7).
REQ-039 target=2, L=1, pattern 1, stream of 1s -> two match pulses, then done=1, in_ready=0, match_cnt=2, further in_valid ignored.
REQ-040 abort and start in the same cycle during RUN -> IDLE, match_cnt held. cfg_we during RUN -> config unchanged.
REQ-041 target=0, L=1, pattern 1, 300 accepted 1s -> match_cnt saturates at 255, state stays RUN.
REQ-042 rst asserted after 3 of 4 pattern bits -> all outputs at reset values, no match pulse. Then start plus 1011 -> match.
